// File: rtl/iob_eth_frame_fifo_ctrl_pkg.sv
// Shared constants and writer state encoding for the Ethernet frame FIFO controller.
package iob_eth_frame_fifo_ctrl_pkg;
  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 8;
  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_ACTIVE = 2'd1,
    WR_DROP   = 2'd2
  } wr_state_t;
endpackage

// File: rtl/iob_eth_frame_fifo_rd.sv
// Read side: prefetches committed entries from the RAM into a 2-entry skid that drives the output.
module iob_eth_frame_fifo_rd
  import iob_eth_frame_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W:0]   cmt_ptr_i,
  output logic [ADDR_W:0]   rd_ptr_o,
  output logic              ram_enB_o,
  output logic [ADDR_W-1:0] ram_addrB_o,
  input  logic [DATA_W:0]   ram_dB_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o
);
  logic [ADDR_W:0] r_rd_ptr;
  logic            r_inflight;
  logic [1:0]      r_cnt;
  logic            r_wsel;
  logic            r_rsel;
  logic [DATA_W:0] r_skid [2];

  logic            w_avail;
  logic            w_pop;
  logic [2:0]      w_occ;
  logic            w_issue;
  logic [DATA_W:0] w_head;

  assign w_avail = (cmt_ptr_i != r_rd_ptr);
  assign w_pop   = (r_cnt != 2'd0) && out_ready_i;
  assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight};
  // Counting the beat leaving this cycle keeps the pipe full at one beat per clock.
  assign w_issue = w_avail && (w_pop ? (w_occ < 3'd3) : (w_occ < 3'd2));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
      r_cnt      <= 2'd0;
      r_wsel     <= 1'b0;
      r_rsel     <= 1'b0;
      r_skid[0]  <= '0;
      r_skid[1]  <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (r_inflight) begin
        r_skid[r_wsel] <= ram_dB_i;
        r_wsel         <= ~r_wsel;
      end
      if (w_pop) r_rsel <= ~r_rsel;
      r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  assign w_head      = r_skid[r_rsel];
  assign rd_ptr_o    = r_rd_ptr;
  assign ram_enB_o   = w_issue;
  assign ram_addrB_o = r_rd_ptr[ADDR_W-1:0];
  assign out_valid_o = (r_cnt != 2'd0);
  assign out_data_o  = w_head[DATA_W-1:0];
  assign out_last_o  = w_head[DATA_W];
endmodule

// File: rtl/iob_eth_frame_fifo_ctrl.sv
// Frame-aware circular buffer controller: speculative frame writes on port A, committed-only reads on port B.
// state     | meaning
// WR_IDLE   | between frames, wr_ptr == cmt_ptr
// WR_ACTIVE | frame in progress, bytes written speculatively past cmt_ptr
// WR_DROP   | frame could not fit; swallow beats until last/abort
module iob_eth_frame_fifo_ctrl
  import iob_eth_frame_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_W-1:0]     in_data_i,
  input  logic                  in_last_i,
  input  logic                  in_abort_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_W-1:0]     out_data_o,
  output logic                  out_last_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o,
  output logic [ADDR_W:0]       level_o,
  output logic                  ram_enA_o,
  output logic                  ram_weA_o,
  output logic [ADDR_W-1:0]     ram_addrA_o,
  output logic [DATA_W:0]       ram_dA_o,
  output logic                  ram_enB_o,
  output logic                  ram_weB_o,
  output logic [ADDR_W-1:0]     ram_addrB_o,
  input  logic [DATA_W:0]       ram_dB_i
);
  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  wr_state_t             r_state;
  logic [ADDR_W:0]       r_wr_ptr;
  logic [ADDR_W:0]       r_cmt_ptr;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  wr_state_t             w_state_nxt;
  logic [ADDR_W:0]       w_wr_nxt;
  logic [ADDR_W:0]       w_cmt_nxt;
  logic [ADDR_W:0]       w_rd_ptr;
  logic                  w_full;
  logic                  w_ovf;
  logic                  w_acc;
  logic                  w_drop;
  logic                  w_wr_en;

  assign w_full     = ((r_wr_ptr - w_rd_ptr) == CAP);
  // Full with nothing committed ahead means the frame alone exceeds capacity.
  assign w_ovf      = (r_state == WR_ACTIVE) && w_full && (r_cmt_ptr == w_rd_ptr);
  assign in_ready_o = (r_state == WR_DROP) || !w_full;
  assign w_acc      = in_valid_i && in_ready_o;

  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = r_wr_ptr;
    w_cmt_nxt   = r_cmt_ptr;
    w_drop      = 1'b0;
    w_wr_en     = 1'b0;
    case (r_state)
      WR_IDLE, WR_ACTIVE: begin
        if (w_ovf) begin
          w_wr_nxt    = r_cmt_ptr;
          w_drop      = 1'b1;
          w_state_nxt = WR_DROP;
        end else if (w_acc) begin
          if (in_abort_i) begin
            w_wr_nxt    = r_cmt_ptr;
            w_drop      = 1'b1;
            w_state_nxt = WR_IDLE;
          end else begin
            w_wr_en  = 1'b1;
            w_wr_nxt = r_wr_ptr + 1'b1;
            if (in_last_i) begin
              w_cmt_nxt   = r_wr_ptr + 1'b1;
              w_state_nxt = WR_IDLE;
            end else begin
              w_state_nxt = WR_ACTIVE;
            end
          end
        end
      end
      WR_DROP: begin
        if (w_acc && (in_last_i || in_abort_i)) w_state_nxt = WR_IDLE;
      end
      default: w_state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= WR_IDLE;
      r_wr_ptr   <= '0;
      r_cmt_ptr  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_ptr  <= w_wr_nxt;
      r_cmt_ptr <= w_cmt_nxt;
      if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}})) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  iob_eth_frame_fifo_rd #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_rd (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cmt_ptr_i  (r_cmt_ptr),
    .rd_ptr_o   (w_rd_ptr),
    .ram_enB_o  (ram_enB_o),
    .ram_addrB_o(ram_addrB_o),
    .ram_dB_i   (ram_dB_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_last_o (out_last_o)
  );

  assign ram_enA_o   = w_wr_en;
  assign ram_weA_o   = w_wr_en;
  assign ram_addrA_o = r_wr_ptr[ADDR_W-1:0];
  assign ram_dA_o    = {in_last_i, in_data_i};
  assign ram_weB_o   = 1'b0;
  assign drop_cnt_o  = r_drop_cnt;
  assign level_o     = r_cmt_ptr - w_rd_ptr;
endmodule

// File: tb/tb_iob_eth_frame_fifo_ctrl.sv
// Directed bench for the frame FIFO controller with a behavioural TDP RAM (16 entries).
module tb_iob_eth_frame_fifo_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          in_abort = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [15:0]   drop_cnt;
  logic [AW:0]   level;
  logic          ram_enA, ram_weA, ram_enB, ram_weB;
  logic [AW-1:0] ram_addrA, ram_addrB;
  logic [DW:0]   ram_dA;
  logic [DW:0]   ram_q = '0;
  logic [DW:0]   mem [16];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iob_eth_frame_fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_last_i(in_last), .in_abort_i(in_abort),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
    .drop_cnt_o(drop_cnt), .level_o(level),
    .ram_enA_o(ram_enA), .ram_weA_o(ram_weA), .ram_addrA_o(ram_addrA), .ram_dA_o(ram_dA),
    .ram_enB_o(ram_enB), .ram_weB_o(ram_weB), .ram_addrB_o(ram_addrB), .ram_dB_i(ram_q)
  );

  always @(posedge clk) begin
    if (ram_enA && ram_weA) mem[ram_addrA] <= ram_dA;
    if (ram_enB) ram_q <= mem[ram_addrB];
  end

  // Monitor: collects output beats, first-valid edge, RAM writes and stall stability.
  logic [DW:0] got_q[$];
  logic [DW:0] exp_q[$];
  int          cyc = 0;
  int          first_valid = -1;
  int          wr_cnt = 0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [DW:0] prev_beat = '0;
  int          last_edge = 0;

  always @(posedge clk) begin
    if (!rst_i && out_valid && out_ready) got_q.push_back({out_last, out_data});
    if (!rst_i && out_valid && first_valid < 0) first_valid = cyc;
    if (ram_enA && ram_weA) wr_cnt++;
    if (prev_stall && !rst_i && (out_valid !== 1'b1 || {out_last, out_data} !== prev_beat)) stall_viol++;
    prev_stall = !rst_i && out_valid && !out_ready;
    prev_beat  = {out_last, out_data};
    cyc++;
  end

  task automatic send_byte(input logic [DW-1:0] d, input logic l, input logic a, output int edge_n);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l; in_abort = a;
    while (!in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      errors++; checks++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    edge_n = cyc - 1;
    in_valid = 1'b0; in_last = 1'b0; in_abort = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [DW-1:0] base, input bit rnd,
                            input int abort_at, input bit keep);
    logic [DW-1:0] d;
    int n;
    for (int i = 0; i < len; i++) begin
      d = rnd ? 8'($urandom_range(0, 255)) : base + 8'(i);
      send_byte(d, i == len - 1, i == abort_at, n);
      if (keep) exp_q.push_back({(i == len - 1), d});
      last_edge = n;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if ({out_valid, out_last, out_data} !== 10'h0) begin errors++; $display("FAIL rst_out got=%b/%b/%h exp=0", out_valid, out_last, out_data); end
    checks++; if (drop_cnt !== 16'h0 || level !== 5'h0) begin errors++; $display("FAIL rst_cnt drop=%h level=%h exp=0", drop_cnt, level); end
    checks++; if ({ram_enA, ram_weA, ram_enB, ram_weB} !== 4'h0) begin errors++; $display("FAIL rst_ram got=%b exp=0000", {ram_enA, ram_weA, ram_enB, ram_weB}); end
    rst_i = 1'b0;
  endtask

  task automatic test_single_frame();
    out_ready = 1'b1;
    first_valid = -1;
    send_frame(4, 8'h11, 0, -1, 1);
    wait_drain();
    checks++; if (first_valid - last_edge !== 3) begin errors++; $display("FAIL latency got=%0d exp=3", first_valid - last_edge); end
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL single_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL single_level got=%0d exp=0", level); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_abort();
    send_frame(3, 8'h21, 0, 2, 0);
    send_frame(2, 8'hA0, 0, -1, 1);
    wait_drain();
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL abort_count got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL abort_drop got=%0d exp=1", drop_cnt); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    int n, e;
    @(negedge clk);
    out_ready = 1'b0;
    send_frame(10, 8'h30, 0, -1, 1);
    repeat (4) @(negedge clk);
    // Two entries prefetched into the skid: 10 committed - 2 issued.
    checks++; if (level !== 5'd8) begin errors++; $display("FAIL bp_level got=%0d exp=8", level); end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!in_ready) break;
      in_valid = 1'b1; in_data = 8'h80 + 8'(i); in_last = 1'b0; in_abort = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n++;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL bp_accepted got=%0d exp=8", n); end
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    for (int i = n; i < 10; i++) send_byte(8'h80 + 8'(i), i == 9, 1'b0, e);
    for (int i = 0; i < 10; i++) exp_q.push_back({(i == 9), 8'h80 + 8'(i)});
    wait_drain();
    checks++; if (got_q.size() !== 20) begin errors++; $display("FAIL bp_count got=%0d exp=20", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL bp_drop got=%0d exp=1", drop_cnt); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    int w0;
    out_ready = 1'b1;
    w0 = wr_cnt;
    send_frame(20, 8'h40, 0, -1, 0);
    repeat (6) @(negedge clk);
    checks++; if (wr_cnt - w0 !== 16) begin errors++; $display("FAIL ovf_writes got=%0d exp=16", wr_cnt - w0); end
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop got=%0d exp=2", drop_cnt); end
    checks++; if (got_q.size() !== 0 || level !== 5'd0) begin errors++; $display("FAIL ovf_no_output beats=%0d level=%0d exp=0", got_q.size(), level); end
    send_frame(3, 8'h50, 0, -1, 1);
    wait_drain();
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL ovf_next_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_next_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random_stall();
    int len, nd;
    bit done;
    nd = 0; done = 0;
    stall_viol = 0;
    fork
      begin
        for (int f = 0; f < 100; f++) begin
          len = $urandom_range(1, 64);
          // Frames longer than the 16-entry buffer always end up dropped.
          send_frame(len, 8'h00, 1, -1, len <= 16);
          if (len > 16) nd++;
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(negedge clk);
    out_ready = 1'b1;
    wait_drain();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (drop_cnt !== 16'(2 + nd)) begin errors++; $display("FAIL rnd_drop got=%0d exp=%0d", drop_cnt, 2 + nd); end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL rnd_stall_stable got=%0d exp=0", stall_viol); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_mid_reset();
    int e;
    @(negedge clk);
    out_ready = 1'b0;
    send_frame(5, 8'h60, 0, -1, 0);
    send_byte(8'h66, 1'b0, 1'b0, e);
    send_byte(8'h67, 1'b0, 1'b0, e);
    repeat (3) @(negedge clk);
    checks++; if (level !== 5'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL mrst_pre level=%0d valid=%b exp=3/1", level, out_valid); end
    rst_i = 1'b1;
    @(negedge clk);
    checks++; if ({out_valid, out_last, out_data} !== 10'h0 || in_ready !== 1'b1) begin errors++; $display("FAIL mrst_out valid=%b last=%b data=%h ready=%b exp=0/0/00/1", out_valid, out_last, out_data, in_ready); end
    checks++; if (level !== 5'd0 || drop_cnt !== 16'd0 || ram_enB !== 1'b0) begin errors++; $display("FAIL mrst_cnt level=%0d drop=%0d enB=%b exp=0", level, drop_cnt, ram_enB); end
    rst_i = 1'b0;
    got_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    send_frame(3, 8'h70, 0, -1, 1);
    wait_drain();
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL mrst_next_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mrst_next_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_abort();
    test_backpressure();
    test_overflow();
    test_random_stall();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
